traffic_light_monitor: RTL and testbench
========================================

Name: traffic_light_monitor

Overview:
- Conflict/sequence monitor on the receiving end of the four-way light buses (north/east/south/west, 3-bit one-hot {red=100, yellow=010, green=001}) produced by the intersection controller.
- Decodes the active phase, times each phase in tick units, and latches the first safety or timing violation with a code.
- Sits beside the controller; its fault output drives the cabinet flash/failsafe logic.

Parameters:
- ALLRED_TICKS, 10, required length of the start-up all-red phase, in ticks
- YEL_TICKS, 5, required yellow length, in ticks
- GRN_TICKS, 30, required green length, in ticks
- CNT_W, 6, width of the phase tick counter; must hold GRN_TICKS+1

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- tick  in  1  timebase enable, one clk wide; tie high to time in clk cycles
- clr  in  1  synchronous fault clear; monitor resynchronises afterwards
- north_lights  in  3  north light bus
- east_lights  in  3  east light bus
- south_lights  in  3  south light bus
- west_lights  in  3  west light bus
- fault  out  1  sticky violation flag
- fault_code  out  3  0 none, 1 ENC, 2 CONFLICT, 3 SEQ, 4 YEL_TIME, 5 GRN_TIME, 6 ALLRED_TIME
- fault_dir  out  2  direction involved: 0 N, 1 E, 2 S, 3 W (0 for ENC/ALLRED)
- cur_dir  out  2  direction of the current yellow/green phase
- cur_phase  out  2  0 all-red, 1 yellow, 2 green, 3 unknown
- phase_cnt  out  CNT_W  ticks counted in the current phase; saturates at all-ones
- cycle_done  out  1  one-clk pulse on a legal W-green to N-yellow transition
- flash_req  out  1  flash request (see Optional Feature)

Behaviour:
- Reset values: all outputs 0; cur_phase = 3. FSM state is SYNC. Input register is loaded with all-red.
- Pipeline: the four buses are registered on every clk. Decode, checks and outputs are registered one cycle later. fault therefore rises on the 2nd clk edge after the offending value is first sampled.
- Decode of the registered buses:
  - Any bus not in {100, 010, 001} gives ENC.
  - More than one bus non-red gives CONFLICT.
  - Otherwise the phase is all-red, or yellow/green of exactly one direction.
- Phase counter:
  - On a phase change (phase or dir differs from the previous registered decode), phase_cnt loads 1 if tick, else 0.
  - Otherwise it increments on tick and saturates.
- Legal transitions:
  - all-red to N-yellow, start-up only.
  - d-yellow to d-green.
  - d-green to (d+1 mod 4)-yellow.
- FSM states:
  - SYNC: waits for all-red (goes to INIT) or any yellow (goes to RUN). ENC/CONFLICT are still checked. No timing or sequence checks.
  - INIT: all-red. Leaving it to N-yellow requires phase_cnt == ALLRED_TICKS, else ALLRED_TIME. Leaving it to anything else is SEQ. phase_cnt > ALLRED_TICKS while still all-red is ALLRED_TIME immediately.
  - RUN: checks every phase change against the legal transitions; violation is SEQ.
    - On exit, yellow requires phase_cnt == YEL_TICKS and green requires phase_cnt == GRN_TICKS; violations are YEL_TIME and GRN_TIME.
    - Overrun (phase_cnt exceeds the limit while still in the phase) flags immediately.
    - Returning to all-red in RUN is SEQ.
  - FAULT: decode and phase_cnt keep running. fault, fault_code and fault_dir are frozen. Only clr or rst leave this state; clr goes to SYNC.
- Simultaneous violations in one cycle: priority ENC > CONFLICT > SEQ > YEL_TIME/GRN_TIME/ALLRED_TIME. Only the first fault is latched.
- fault_dir:
  - CONFLICT: lowest-index non-red direction.
  - SEQ: new phase's direction.
  - TIME: direction of the phase being timed.
- clr in the same cycle as a new violation: clr wins and the FSM goes to SYNC. The violation is not latched; the checks re-arm after sync.
- Reset mid-operation: everything returns to reset values immediately (asynchronous). The first legal all-red restarts INIT.
- cycle_done pulses only in RUN, and only on a fully legal W-green to N-yellow transition with correct green timing.

Optional Feature:
- Macro: TLM_FLASH_EN
- Defined: while fault = 1, flash_req toggles on every tick (starting at 1 on the first tick after fault sets). It returns to 0 on clr or rst.
- Undefined: flash_req is tied to 0 and no toggle logic is built.

Test Plan:
- tick=1. Controller-legal sequence: all-red 10 cycles, N-yel 5, N-grn 30, E, S, W, back to N-yel. Expect fault=0, and cycle_done pulses once, 2 cycles after N-yellow is driven.
- From a legal N-green, drive north=001 and east=010 together. Expect fault=1, fault_code=2, fault_dir=0, two edges later.
- Drive south_lights=011 while in RUN. Expect fault_code=1 even though a CONFLICT also exists in the same cycle.
- N-yellow held 4 ticks then N-green. Expect fault_code=4, fault_dir=0. Then pulse clr and drive a legal E-yellow. Expect fault=0, RUN resumes, and later violations are detected.
- E-green lasts 31 ticks. Expect fault_code=5 on the cycle phase_cnt reaches 31, before the phase ends. Also N-green followed by S-yellow: expect fault_code=3, fault_dir=2.
- With TLM_FLASH_EN and tick every 4 clks: after a fault, flash_req toggles every 4 clks. Assert rst low mid-phase: all outputs are 0 immediately and cur_phase=3.

Source files
------------

// File: rtl/traffic_light_monitor.sv
// Conflict/sequence monitor for a four-way intersection: decodes the light buses,
// times each phase in ticks and latches the first violation. `TLM_FLASH_EN builds flash_req.
module traffic_light_monitor #(
    parameter int ALLRED_TICKS = 10,
    parameter int YEL_TICKS    = 5,
    parameter int GRN_TICKS    = 30,
    parameter int CNT_W        = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             clr,
    input  logic [2:0]       north_lights,
    input  logic [2:0]       east_lights,
    input  logic [2:0]       south_lights,
    input  logic [2:0]       west_lights,
    output logic             fault,
    output logic [2:0]       fault_code,
    output logic [1:0]       fault_dir,
    output logic [1:0]       cur_dir,
    output logic [1:0]       cur_phase,
    output logic [CNT_W-1:0] phase_cnt,
    output logic             cycle_done,
    output logic             flash_req
);

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    localparam logic [CNT_W-1:0] ALLRED_LIM = CNT_W'(ALLRED_TICKS);
    localparam logic [CNT_W-1:0] YEL_LIM    = CNT_W'(YEL_TICKS);
    localparam logic [CNT_W-1:0] GRN_LIM    = CNT_W'(GRN_TICKS);

    typedef enum logic [1:0] {PH_ALLRED, PH_YEL, PH_GRN, PH_UNK} phase_e;
    typedef enum logic [1:0] {S_SYNC, S_INIT, S_RUN, S_FAULT} state_e;
    typedef enum logic [2:0] {
        F_NONE, F_ENC, F_CONFLICT, F_SEQ, F_YEL_TIME, F_GRN_TIME, F_ALLRED_TIME
    } fault_e;

    logic [2:0]       bus_q [4];
    state_e           state, state_next;
    phase_e           phase_q, dec_phase;
    logic [1:0]       dir_q, dec_dir;
    logic [CNT_W-1:0] cnt_q, cnt_next;
    logic             fault_q, done_q, done_next;
    fault_e           code_q, viol;
    logic [1:0]       fdir_q, viol_dir;

    logic             enc, conflict, changed, legal;
    logic [2:0]       n_lit;
    logic [1:0]       low_dir;
    logic [2:0]       low_bus;

    // Decode of the registered buses; the loop runs high-to-low so the lowest lit index wins.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        enc     = 1'b0;
        n_lit   = '0;
        low_dir = '0;
        low_bus = RED;
        for (int i = 3; i >= 0; i--) begin
            if (!(bus_q[i] inside {RED, YEL, GRN})) enc = 1'b1;
            if (bus_q[i] != RED) begin
                n_lit   = n_lit + 3'd1;
                low_dir = 2'(i);
                low_bus = bus_q[i];
            end
        end
        conflict  = (n_lit > 3'd1);
        dec_phase = PH_ALLRED;
        dec_dir   = '0;
        if (enc || conflict) begin
            dec_phase = PH_UNK;
        end else if (n_lit == 3'd1) begin
            dec_phase = (low_bus == YEL) ? PH_YEL : PH_GRN;
            dec_dir   = low_dir;
        end
    end

    always_comb begin
        changed = (dec_phase != phase_q) || (dec_dir != dir_q);
        if (changed)
            cnt_next = tick ? CNT_W'(1) : '0;
        else if (tick && !(&cnt_q))
            cnt_next = cnt_q + CNT_W'(1);
        else
            cnt_next = cnt_q;
        legal = ((phase_q == PH_YEL) && (dec_phase == PH_GRN) && (dec_dir == dir_q)) ||
                ((phase_q == PH_GRN) && (dec_phase == PH_YEL) && (dec_dir == dir_q + 2'd1));
    end

    // Next-state and violation detection; the priority order is encoded by overwrite order.
    always_comb begin
        state_next = state;
        viol       = F_NONE;
        viol_dir   = '0;
        done_next  = 1'b0;
        case (state)
            S_SYNC: begin
                if (dec_phase == PH_ALLRED)   state_next = S_INIT;
                else if (dec_phase == PH_YEL) state_next = S_RUN;
            end
            S_INIT: begin
                if (changed) begin
                    if (dec_phase == PH_YEL && dec_dir == 2'd0) begin
                        if (cnt_q != ALLRED_LIM) viol = F_ALLRED_TIME;
                        else                     state_next = S_RUN;
                    end else begin
                        viol     = F_SEQ;
                        viol_dir = dec_dir;
                    end
                end else if (cnt_next > ALLRED_LIM) begin
                    viol = F_ALLRED_TIME;
                end
            end
            S_RUN: begin
                if (changed) begin
                    if (!legal) begin
                        viol     = F_SEQ;
                        viol_dir = dec_dir;
                    end else if (phase_q == PH_YEL && cnt_q != YEL_LIM) begin
                        viol     = F_YEL_TIME;
                        viol_dir = dir_q;
                    end else if (phase_q == PH_GRN && cnt_q != GRN_LIM) begin
                        viol     = F_GRN_TIME;
                        viol_dir = dir_q;
                    end else if (phase_q == PH_GRN && dir_q == 2'd3) begin
                        done_next = 1'b1;
                    end
                end else if (phase_q == PH_YEL && cnt_next > YEL_LIM) begin
                    viol     = F_YEL_TIME;
                    viol_dir = dir_q;
                end else if (phase_q == PH_GRN && cnt_next > GRN_LIM) begin
                    viol     = F_GRN_TIME;
                    viol_dir = dir_q;
                end
            end
            default: ;
        endcase

        if (state != S_FAULT) begin
            if (enc) begin
                viol     = F_ENC;
                viol_dir = '0;
            end else if (conflict) begin
                viol     = F_CONFLICT;
                viol_dir = low_dir;
            end
        end
        if (viol != F_NONE) begin
            state_next = S_FAULT;
            done_next  = 1'b0;
        end
        // A clear always wins, even against a violation detected on the same edge.
        if (clr) begin
            state_next = S_SYNC;
            viol       = F_NONE;
            viol_dir   = '0;
            done_next  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the bus registers are reset to all-red so the first decode is a legal phase.
            for (int i = 0; i < 4; i++) bus_q[i] <= RED;
            state   <= S_SYNC;
            phase_q <= PH_UNK;
            dir_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
            code_q  <= F_NONE;
            fdir_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            bus_q[0] <= north_lights;
            bus_q[1] <= east_lights;
            bus_q[2] <= south_lights;
            bus_q[3] <= west_lights;
            state    <= state_next;
            phase_q  <= dec_phase;
            dir_q    <= dec_dir;
            cnt_q    <= cnt_next;
            done_q   <= done_next;
            if (clr) begin
                fault_q <= 1'b0;
                code_q  <= F_NONE;
                fdir_q  <= '0;
            end else if (viol != F_NONE) begin
                fault_q <= 1'b1;
                code_q  <= viol;
                fdir_q  <= viol_dir;
            end
        end
    end

    assign fault      = fault_q;
    assign fault_code = code_q;
    assign fault_dir  = fdir_q;
    assign cur_dir    = dir_q;
    assign cur_phase  = phase_q;
    assign phase_cnt  = cnt_q;
    assign cycle_done = done_q;

`ifdef TLM_FLASH_EN
    logic flash_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)               flash_q <= 1'b0;
        else if (clr || !fault_q) flash_q <= 1'b0;
        else if (tick)          flash_q <= ~flash_q;
    end

    assign flash_req = flash_q;
`else
    assign flash_req = 1'b0;
`endif

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Scoreboard bench for traffic_light_monitor: directed phases push expected values keyed
// by clock edge; a monitor process pops and compares them on the falling edge.
module tb_traffic_light_monitor;

    localparam int CNT_W = 6;
    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    typedef enum int {S_FAULT, S_CODE, S_DIR, S_CDIR, S_PHASE, S_CNT, S_DONE, S_FLASH} sig_e;
    typedef struct {
        int   cyc;
        sig_e sig;
        int   val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   edge_n = 0;
    int   done_count = 0;
    bit   div4 = 1'b0;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             tick = 1'b1;
    logic             clr = 1'b0;
    logic [2:0]       nl = RED, el = RED, sl = RED, wl = RED;
    logic             fault, cycle_done, flash_req;
    logic [2:0]       fault_code;
    logic [1:0]       fault_dir, cur_dir, cur_phase;
    logic [CNT_W-1:0] phase_cnt;

    traffic_light_monitor #(
        .ALLRED_TICKS(10), .YEL_TICKS(5), .GRN_TICKS(30), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick), .clr(clr),
        .north_lights(nl), .east_lights(el), .south_lights(sl), .west_lights(wl),
        .fault(fault), .fault_code(fault_code), .fault_dir(fault_dir),
        .cur_dir(cur_dir), .cur_phase(cur_phase), .phase_cnt(phase_cnt),
        .cycle_done(cycle_done), .flash_req(flash_req)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    // tick is high for every edge, or only for edges whose number is a multiple of 4
    initial forever begin
        @(posedge clk);
        #1;
        tick = div4 ? ((edge_n + 1) % 4 == 0) : 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic check(string name, logic [31:0] act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s edge=%0d got=%0d expected=%0d", name, edge_n, act, exp);
        end
    endtask

    function automatic logic [31:0] get_sig(sig_e s);
        case (s)
            S_FAULT: return {31'd0, fault};
            S_CODE:  return {29'd0, fault_code};
            S_DIR:   return {30'd0, fault_dir};
            S_CDIR:  return {30'd0, cur_dir};
            S_PHASE: return {30'd0, cur_phase};
            S_CNT:   return {26'd0, phase_cnt};
            S_DONE:  return {31'd0, cycle_done};
            default: return {31'd0, flash_req};
        endcase
    endfunction

    // Monitor: compares every expectation due at or before the current edge.
    initial begin
        exp_t item;
        forever begin
            @(negedge clk);
            if (cycle_done === 1'b1) done_count++;
            while (sb.size() > 0 && sb[0].cyc <= edge_n) begin
                item = sb.pop_front();
                check(item.sig.name(), get_sig(item.sig), item.val);
            end
        end
    end

    task automatic expect_at(int cyc, sig_e s, int v);
        exp_t item;
        int idx = sb.size();
        item.cyc = cyc;
        item.sig = s;
        item.val = v;
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].cyc > cyc) begin
                idx = i;
                break;
            end
        end
        sb.insert(idx, item);
    endtask

    task automatic expect_fault(int cyc, int code, int dir);
        expect_at(cyc - 1, S_FAULT, 0);
        expect_at(cyc, S_FAULT, 1);
        expect_at(cyc, S_CODE, code);
        expect_at(cyc, S_DIR, dir);
    endtask

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_phase(int ph, int dir);
        logic [2:0] v;
        v  = (ph == 1) ? YEL : (ph == 2) ? GRN : RED;
        nl = RED; el = RED; sl = RED; wl = RED;
        if (ph != 0) begin
            case (dir)
                0: nl = v;
                1: el = v;
                2: sl = v;
                default: wl = v;
            endcase
        end
    endtask

    // A legal phase held for n samples: counts 1..n across its n decodes.
    task automatic run_phase(int ph, int dir, int n);
        int e = edge_n;
        set_phase(ph, dir);
        expect_at(e + 2, S_PHASE, ph);
        expect_at(e + 2, S_CDIR, (ph == 0) ? 0 : dir);
        expect_at(e + 2, S_CNT, 1);
        expect_at(e + n + 1, S_CNT, n);
        expect_at(e + n + 1, S_FAULT, 0);
        step(n);
    endtask

    // Clear with all-red on the bus, then complete a 10-tick all-red start-up phase.
    task automatic restart_allred();
        int e = edge_n;
        set_phase(0, 0);
        clr = 1'b1;
        expect_at(e + 1, S_FAULT, 0);
        expect_at(e + 1, S_CODE, 0);
        step(1);
        clr = 1'b0;
        expect_at(e + 2, S_PHASE, 0);
        expect_at(e + 11, S_CNT, 10);
        step(9);
    endtask

    initial begin
        int e, f, t1, guard;

        // reset state while rst is held low
        set_phase(0, 0);
        step(3);
        expect_at(edge_n, S_FAULT, 0);
        expect_at(edge_n, S_CODE, 0);
        expect_at(edge_n, S_DIR, 0);
        expect_at(edge_n, S_CDIR, 0);
        expect_at(edge_n, S_PHASE, 3);
        expect_at(edge_n, S_CNT, 0);
        expect_at(edge_n, S_DONE, 0);
        expect_at(edge_n, S_FLASH, 0);
        step(1);
        rst = 1'b1;

        // legal cycle; the reset-loaded all-red register is the first all-red tick
        e = edge_n;
        expect_at(e + 1, S_PHASE, 0);
        expect_at(e + 1, S_CNT, 1);
        expect_at(e + 10, S_CNT, 10);
        step(9);
        for (int d = 0; d < 4; d++) begin
            run_phase(1, d, 5);
            run_phase(2, d, 30);
        end
        e = edge_n;
        expect_at(e + 1, S_DONE, 0);
        expect_at(e + 2, S_DONE, 1);
        expect_at(e + 3, S_DONE, 0);
        run_phase(1, 0, 5);
        run_phase(2, 0, 10);

        // N green plus E yellow: CONFLICT in N
        e = edge_n;
        nl = GRN;
        el = YEL;
        expect_fault(e + 2, 2, 0);
        step(2);
        expect_at(edge_n + 1, S_CODE, 2);
        step(1);

        // bad encoding on south while north is green: ENC beats CONFLICT
        restart_allred();
        run_phase(1, 0, 5);
        run_phase(2, 0, 5);
        e = edge_n;
        sl = 3'b011;
        expect_fault(e + 2, 1, 0);
        step(2);

        // short N yellow (4 ticks): YEL_TIME
        restart_allred();
        e = edge_n;
        set_phase(1, 0);
        step(4);
        e = edge_n;
        set_phase(2, 0);
        expect_fault(e + 2, 4, 0);
        step(2);

        // clear during N green, resume on E yellow
        clr = 1'b1;
        expect_at(edge_n + 1, S_FAULT, 0);
        step(1);
        clr = 1'b0;
        run_phase(1, 1, 5);

        // E green overruns: GRN_TIME as the count reaches 31
        e = edge_n;
        set_phase(2, 1);
        expect_at(e + 31, S_CNT, 30);
        expect_fault(e + 32, 5, 1);
        expect_at(e + 32, S_CNT, 31);
        step(32);

        // resync on N yellow, then N green followed by S yellow: SEQ in S
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        run_phase(1, 0, 5);
        run_phase(2, 0, 30);
        e = edge_n;
        set_phase(1, 2);
        expect_fault(e + 2, 3, 2);
        step(2);

        // flash behaviour with tick on every 4th edge
        div4 = 1'b1;
        step(2);
        set_phase(0, 0);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        e = edge_n;
        nl = GRN;
        el = GRN;
        f  = e + 2;
        expect_fault(f, 2, 0);
        t1 = ((f / 4) + 1) * 4;
        for (int c = f; c <= t1 + 9; c++) begin
`ifdef TLM_FLASH_EN
            expect_at(c, S_FLASH, (c < t1) ? 0 : ((((c - t1) / 4) % 2 == 0) ? 1 : 0));
`else
            expect_at(c, S_FLASH, 0);
`endif
        end
        step(t1 + 10 - edge_n);

        // asynchronous reset while faulted and mid-phase
        rst = 1'b0;
        expect_at(edge_n, S_FAULT, 0);
        expect_at(edge_n, S_CODE, 0);
        expect_at(edge_n, S_PHASE, 3);
        expect_at(edge_n, S_CNT, 0);
        expect_at(edge_n, S_FLASH, 0);
        div4 = 1'b0;
        set_phase(0, 0);
        step(3);
        rst = 1'b1;
        e = edge_n;
        expect_at(e + 1, S_PHASE, 0);
        expect_at(e + 1, S_CNT, 1);
        step(9);
        run_phase(1, 0, 5);

        guard = 0;
        while (sb.size() > 0 && guard < 100) begin
            step(1);
            guard++;
        end
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb.size());
        end
        check("cycle_done_pulses", done_count, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
